br_cmp_pipe: RTL and testbench
==============================

// Module: br_cmp_pipe
// PURPOSE
//  Parametrised, pipelined branch comparator for the EX stage of the pipelined RV32I core.
//  - Evaluates the six RV32I branch conditions on WIDTH-bit operands.
//  - Carries a tag and the predicted direction through STAGES register stages.
//  - Reports the branch outcome, a mispredict flag and an illegal-funct3 flag.
//  - Valid/ready flow control with per-stage stall; a flush input kills all in-flight entries.
// PARAMETERS
//  WIDTH   32  operand width in bits (>=2)
//  STAGES  1   result register stages, 1..4; latency = STAGES cycles when out_ready=1
//  TAG_W   5   width of the opaque tag carried alongside each compare
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  flush       in   1       synchronous kill of all in-flight entries
//  in_valid    in   1       request valid
//  in_ready    out  1       stage 0 can accept a request this cycle
//  in_cmpop    in   3       branch_funct3_t (beq,bne,blt,bge,bltu,bgeu)
//  in_a        in   WIDTH   rs1 operand
//  in_b        in   WIDTH   rs2 operand
//  in_pred     in   1       predicted taken
//  in_tag      in   TAG_W   opaque tag, returned unchanged
//  out_valid   out  1       result valid
//  out_ready   in   1       consumer accepts result
//  out_br_en   out  1       branch taken
//  out_mispred out  1       out_br_en != predicted direction (0 when out_illegal=1)
//  out_illegal out  1       cmpop is 3'b010 or 3'b011
//  out_tag     out  TAG_W   tag of this result
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valid bits clear -> out_valid=0, in_ready=1.
//    out_br_en, out_mispred, out_illegal and out_tag reset to 0. Data regs may hold.
//  - Compare: combinational from in_*; result captured into stage 0 on in_valid&&in_ready.
//    - beq/bne: equality on WIDTH bits.
//    - blt/bge: signed compare. bltu/bgeu: unsigned compare.
//    - Illegal funct3: br_en=0, illegal=1, mispred=0. No X ever propagates.
//  - Pipeline, per stage i (last stage = STAGES-1 drives out_*):
//    - ready_i = !valid_i || ready_{i+1}; ready_{STAGES} = out_ready; in_ready = ready_0.
//    - On ready_i, stage i loads stage i-1 (or the input); valid_i follows valid_{i-1}.
//    - Full throughput: 1 result/cycle while out_ready=1. No bubbles are inserted.
//  - Stall: out_valid=1 && out_ready=0 holds every out_* stable until accepted.
//  - Handshake: out_valid must not drop without out_ready. in_valid may drop freely.
//  - Flush: at the next edge all valid_i clear, and no input is captured that cycle.
//    - in_ready reads 1 during flush, but no acceptance occurs.
//    - Flush beats simultaneous in_valid and out_ready.
//    - out_valid=0 on the cycle after flush.
//  - Reset mid-operation: in-flight entries are discarded immediately (async).
//  - Boundaries (no special-casing; plain WIDTH-bit compare):
//    - a=b=MIN_SIGNED.
//    - a=0 with b=all-ones: signed a>b, unsigned a<b.
// STRUCTURE
//  - Shared package rv32i_types, reused: branch_funct3_t.
//  - Added to rv32i_types: typedef br_res_t {br_en, mispred, illegal, tag}
//    (tag width from package localparam BR_TAG_W, default 5);
//    constants BR_F3_ILL0=3'b010, BR_F3_ILL1=3'b011.
//  - Sub-module br_cmp_stage: one valid/ready register slice holding br_res_t,
//    with flush and async reset.
//  - Top: combinational compare + mispredict logic, then a generate loop of STAGES slices.
// TESTING
//  1. Each op, STAGES=1, out_ready=1:
//     - beq a=5,b=5 -> br_en=1.
//     - blt a=32'hFFFF_FFFF,b=0 -> br_en=1.
//     - bltu same operands -> br_en=0.
//     - bge a=32'h8000_0000,b=32'h8000_0000 -> br_en=1.
//     Each result appears 1 cycle after acceptance.
//  2. Mispredict and illegal:
//     - bne a=1,b=1,pred=1 -> br_en=0, mispred=1.
//     - cmpop=3'b011 -> illegal=1, br_en=0, mispred=0.
//  3. Back-pressure, STAGES=3: stream tags 0..9, out_ready=0 on cycles 4-7
//     -> in_ready drops once the pipe is full; outputs stay stable while stalled;
//     all 10 tags emerge in order with none lost or duplicated.
//  4. Flush: 3 entries in flight, assert flush together with in_valid
//     -> out_valid=0 next cycle; the flushing-cycle request is never emitted;
//     the next request has latency 3.
//  5. Reset: drop rst_n asynchronously between edges with entries in flight
//     -> out_valid=0 immediately; after release in_ready=1 and normal operation resumes.
//  6. WIDTH=8 random: 10k compares checked against a reference model, all ops,
//     with random out_ready.

Source files
------------

// File: rtl/br_cmp_pipe_pkg.sv
// Shared RV32I type definitions used by the branch comparator pipeline.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package rv32i_types;

  // RV32I branch funct3 encodings; 3'b010 and 3'b011 are unused by the ISA.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_funct3_t;

  localparam int         BR_TAG_W   = 5;
  localparam logic [2:0] BR_F3_ILL0 = 3'b010;
  localparam logic [2:0] BR_F3_ILL1 = 3'b011;

  // Result word carried down the comparator pipeline.
  typedef struct packed {
    logic                br_en;
    logic                mispred;
    logic                illegal;
    logic [BR_TAG_W-1:0] tag;
  } br_res_t;

  // True for the two funct3 values that do not encode a branch.
  function automatic logic br_f3_illegal(input logic [2:0] f3);
    return (f3 == BR_F3_ILL0) || (f3 == BR_F3_ILL1);
  endfunction

endpackage

// File: rtl/br_cmp_pipe_if.sv
// Request/response bundle of the branch comparator pipeline.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready valid-ready pairs on both sides.
interface br_cmp_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_cmpop;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_pred;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             out_br_en;
  logic             out_mispred;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  // Requester / result consumer side.
  modport master (
    output in_valid, in_cmpop, in_a, in_b, in_pred, in_tag, out_ready,
    input  in_ready, out_valid, out_br_en, out_mispred, out_illegal, out_tag
  );

  // Comparator side.
  modport slave (
    input  in_valid, in_cmpop, in_a, in_b, in_pred, in_tag, out_ready,
    output in_ready, out_valid, out_br_en, out_mispred, out_illegal, out_tag
  );

endinterface

// File: rtl/br_cmp_pipe_stage.sv
// One valid/ready register slice of the comparator result pipeline.
// Latency: 1 cycle; full throughput (ready looks through to downstream).
// Backpressure: holds its entry while dn_rdy=0; flush and reset drop the entry.
module br_cmp_stage
  import rv32i_types::*;
#(
  parameter type T = br_res_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic up_vld,
  output logic up_rdy,
  input  T     up_dat,
  output logic dn_vld,
  input  logic dn_rdy,
  output T     dn_dat
);

  logic vld_q;
  T     dat_q;

  // Slice can take a new entry when empty or when its entry leaves this cycle.
  assign up_rdy = !vld_q || dn_rdy;

  // Valid bit and payload register; flush wins over any load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (up_rdy) begin
      vld_q <= up_vld;
      if (up_vld) begin
        dat_q <= up_dat;
      end
    end
  end

  assign dn_vld = vld_q;
  assign dn_dat = dat_q;

endmodule

// File: rtl/br_cmp_pipe.sv
// Pipelined RV32I branch comparator: outcome, mispredict and illegal-funct3 flags.
// Latency: STAGES cycles from acceptance to out_valid, one result per cycle.
// Backpressure: out_ready=0 freezes the last slice and ripples back to in_ready.
module br_cmp_pipe
  import rv32i_types::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = BR_TAG_W
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush,
  br_cmp_pipe_if.slave bus
);

  typedef struct packed {
    logic             br_en;
    logic             mispred;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             eq;
  logic             lt_s;
  logic             lt_u;
  logic             br_en;
  logic             illegal;
  res_t             in_res;

  assign op_a = bus.in_a;
  assign op_b = bus.in_b;

  // Plain WIDTH-bit compares; illegal funct3 forces a not-taken, non-mispredicted result.
  always_comb begin
    eq      = (op_a == op_b);
    lt_s    = ($signed(op_a) < $signed(op_b));
    lt_u    = (op_a < op_b);
    illegal = br_f3_illegal(bus.in_cmpop);
    br_en   = 1'b0;
    case (bus.in_cmpop)
      BR_BEQ:  br_en = eq;
      BR_BNE:  br_en = !eq;
      BR_BLT:  br_en = lt_s;
      BR_BGE:  br_en = !lt_s;
      BR_BLTU: br_en = lt_u;
      BR_BGEU: br_en = !lt_u;
      default: br_en = 1'b0;
    endcase
    in_res.br_en   = br_en;
    in_res.mispred = !illegal && (br_en != bus.in_pred);
    in_res.illegal = illegal;
    in_res.tag     = bus.in_tag;
  end

  // Chain of STAGES slices; each slice's ready looks at the next one (or out_ready).
  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    logic up_vld;
    res_t up_dat;
    logic dn_rdy;
    logic vld;
    res_t dat;
    logic rdy;

    if (i == 0) begin : g_head
      assign up_vld = bus.in_valid;
      assign up_dat = in_res;
    end else begin : g_body
      assign up_vld = g_stg[i-1].vld;
      assign up_dat = g_stg[i-1].dat;
    end

    if (i == STAGES - 1) begin : g_tail
      assign dn_rdy = bus.out_ready;
    end else begin : g_link
      assign dn_rdy = g_stg[i+1].rdy;
    end

    br_cmp_stage #(.T(res_t)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .up_vld (up_vld),
      .up_rdy (rdy),
      .up_dat (up_dat),
      .dn_vld (vld),
      .dn_rdy (dn_rdy),
      .dn_dat (dat)
    );
  end

  // in_ready reads 1 during flush; the slices themselves refuse the load.
  assign bus.in_ready    = g_stg[0].rdy || flush;
  assign bus.out_valid   = g_stg[STAGES-1].vld;
  assign bus.out_br_en   = g_stg[STAGES-1].dat.br_en;
  assign bus.out_mispred = g_stg[STAGES-1].dat.mispred;
  assign bus.out_illegal = g_stg[STAGES-1].dat.illegal;
  assign bus.out_tag     = g_stg[STAGES-1].dat.tag;

endmodule

// File: tb/tb_br_cmp_pipe.sv
// Directed and random checks of br_cmp_pipe in three configurations.
// Latency: n/a.
// Backpressure: driven from the bench via out_ready.
module tb_br_cmp_pipe;
  import rv32i_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic f1, f3, f8;

  br_cmp_pipe_if #(.WIDTH(32), .TAG_W(5)) if1 ();
  br_cmp_pipe_if #(.WIDTH(32), .TAG_W(5)) if3 ();
  br_cmp_pipe_if #(.WIDTH(8),  .TAG_W(5)) if8 ();

  br_cmp_pipe #(.WIDTH(32), .STAGES(1), .TAG_W(5)) u_s1 (.clk(clk), .rst_n(rst_n), .flush(f1), .bus(if1));
  br_cmp_pipe #(.WIDTH(32), .STAGES(3), .TAG_W(5)) u_s3 (.clk(clk), .rst_n(rst_n), .flush(f3), .bus(if3));
  br_cmp_pipe #(.WIDTH(8),  .STAGES(2), .TAG_W(5)) u_w8 (.clk(clk), .rst_n(rst_n), .flush(f8), .bus(if8));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if1.in_valid = 1'b0; if1.in_cmpop = 3'd0; if1.in_a = '0; if1.in_b = '0;
    if1.in_pred = 1'b0; if1.in_tag = '0; if1.out_ready = 1'b1;
    if3.in_valid = 1'b0; if3.in_cmpop = 3'd0; if3.in_a = '0; if3.in_b = '0;
    if3.in_pred = 1'b0; if3.in_tag = '0; if3.out_ready = 1'b1;
    if8.in_valid = 1'b0; if8.in_cmpop = 3'd0; if8.in_a = '0; if8.in_b = '0;
    if8.in_pred = 1'b0; if8.in_tag = '0; if8.out_ready = 1'b1;
  endtask

  // Reference for the 8-bit unit: signed order via sign-bit flip, packed {br,mis,ill,tag}.
  function automatic logic [7:0] exp8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                      input logic pred, input logic [4:0] tag);
    logic ill, br, mis;
    ill = (op == 3'd2) || (op == 3'd3);
    case (op)
      3'd0:    br = (a == b);
      3'd1:    br = (a != b);
      3'd4:    br = ((a ^ 8'h80) < (b ^ 8'h80));
      3'd5:    br = !((a ^ 8'h80) < (b ^ 8'h80));
      3'd6:    br = (a < b);
      3'd7:    br = !(a < b);
      default: br = 1'b0;
    endcase
    mis = ill ? 1'b0 : (br ^ pred);
    return {br, mis, ill, tag};
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        pred;
    logic        br;
    logic        mis;
    logic        ill;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  // Waits up to 20 cycles for out_valid on the 3-stage unit, returns cycles since acceptance.
  task automatic wait_out3(output int lat);
    lat = 1;
    while (!if3.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int nt, no, cyc, lat, cnt, sent, got;
    logic saw_low, stalled;
    logic [7:0] prev8;
    logic [5:0] prev3;
    logic [7:0] e8;
    logic [31:0] r;
    logic [7:0] ra;
    logic [4:0] nt5;
    logic [4:0] no5;
    logic [7:0] q8 [$];

    vecs[0]  = '{BR_BEQ,  32'd5,          32'd5,          1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{BR_BLT,  32'hFFFF_FFFF,  32'd0,          1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{BR_BLTU, 32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{BR_BGE,  32'h8000_0000,  32'h8000_0000,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{BR_BNE,  32'd1,          32'd1,          1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'b011,  32'd7,          32'd7,          1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{BR_BLT,  32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{BR_BLTU, 32'd0,          32'hFFFF_FFFF,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{BR_BGEU, 32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{3'b010,  32'd3,          32'd4,          1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{BR_BEQ,  32'h8000_0000,  32'h8000_0000,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{BR_BLT,  32'h8000_0000,  32'h8000_0000,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{BR_BNE,  32'd5,          32'd6,          1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{BR_BGEU, 32'h8000_0000,  32'h7FFF_FFFF,  1'b0, 1'b1, 1'b1, 1'b0};

    // ---------------- reset state ----------------
    rst_n = 1'b0; f1 = 1'b0; f3 = 1'b0; f8 = 1'b0;
    idle_all();
    #3;
    check("rst_s1_vld",  64'(if1.out_valid), 64'(1'b0));
    check("rst_s1_rdy",  64'(if1.in_ready),  64'(1'b1));
    check("rst_s1_flds", 64'({if1.out_br_en, if1.out_mispred, if1.out_illegal, if1.out_tag}), 64'(0));
    check("rst_s3_vld",  64'(if3.out_valid), 64'(1'b0));
    check("rst_s3_rdy",  64'(if3.in_ready),  64'(1'b1));
    check("rst_w8_vld",  64'(if8.out_valid), 64'(1'b0));
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------- each op, back to back, STAGES=1 ----------------
    for (int i = 0; i < NV; i++) begin
      if1.in_valid = 1'b1;
      if1.in_cmpop = vecs[i].op;
      if1.in_a     = vecs[i].a;
      if1.in_b     = vecs[i].b;
      if1.in_pred  = vecs[i].pred;
      if1.in_tag   = 5'(i);
      #1;
      check($sformatf("op_inrdy%0d", i), 64'(if1.in_ready), 64'(1'b1));
      tick();
      check($sformatf("op_vec%0d", i),
            64'({if1.out_valid, if1.out_br_en, if1.out_mispred, if1.out_illegal, if1.out_tag}),
            64'({1'b1, vecs[i].br, vecs[i].mis, vecs[i].ill, 5'(i)}));
    end
    if1.in_valid = 1'b0;
    tick();
    check("op_drain", 64'(if1.out_valid), 64'(1'b0));

    // ---------------- back-pressure, STAGES=3 ----------------
    nt = 0; no = 0; cyc = 0; saw_low = 1'b0; stalled = 1'b0; prev3 = '0;
    while (no < 10 && cyc < 100) begin
      nt5 = nt[4:0];
      if3.out_ready = !(cyc >= 4 && cyc <= 7);
      if3.in_valid  = (nt < 10);
      if3.in_cmpop  = BR_BLT;
      if3.in_a      = nt;
      if3.in_b      = 32'd5;
      if3.in_pred   = 1'b0;
      if3.in_tag    = nt5;
      #1;
      if (stalled) begin
        check("bp_hold", 64'({if3.out_valid, if3.out_tag, if3.out_br_en}), 64'({1'b1, prev3}));
      end
      if (!if3.in_ready) saw_low = 1'b1;
      if (if3.out_valid && if3.out_ready) begin
        no5 = no[4:0];
        check($sformatf("bp_out%0d", no), 64'({if3.out_tag, if3.out_br_en}), 64'({no5, (no < 5)}));
        no++;
      end
      stalled = if3.out_valid && !if3.out_ready;
      prev3   = {if3.out_tag, if3.out_br_en};
      if (if3.in_valid && if3.in_ready) nt++;
      tick();
      cyc++;
    end
    if3.in_valid = 1'b0;
    check("bp_count", 64'(no), 64'(10));
    check("bp_inrdy_drop", 64'(saw_low), 64'(1'b1));
    if3.out_ready = 1'b1;
    tick();
    check("bp_no_extra", 64'(if3.out_valid), 64'(1'b0));

    // ---------------- flush, STAGES=3 ----------------
    for (int k = 1; k <= 3; k++) begin
      if3.in_valid = 1'b1; if3.in_cmpop = BR_BEQ; if3.in_a = 32'd1; if3.in_b = 32'd1;
      if3.in_tag = 5'(k);
      tick();
    end
    if3.in_tag = 5'd7;
    f3 = 1'b1;
    #1;
    check("fl_inrdy", 64'(if3.in_ready), 64'(1'b1));
    tick();
    f3 = 1'b0;
    if3.in_valid = 1'b0;
    check("fl_out0", 64'(if3.out_valid), 64'(1'b0));
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (if3.out_valid) cnt++;
    end
    check("fl_no_emit", 64'(cnt), 64'(0));
    if3.in_valid = 1'b1; if3.in_cmpop = BR_BEQ; if3.in_a = 32'd3; if3.in_b = 32'd3;
    if3.in_pred = 1'b1; if3.in_tag = 5'd9;
    tick();
    if3.in_valid = 1'b0;
    wait_out3(lat);
    check("fl_lat", 64'(lat), 64'(3));
    check("fl_res", 64'({if3.out_valid, if3.out_br_en, if3.out_mispred, if3.out_tag}),
          64'({1'b1, 1'b1, 1'b0, 5'd9}));
    tick();

    // ---------------- asynchronous reset mid-flight ----------------
    if3.out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if3.in_valid = 1'b1; if3.in_cmpop = BR_BNE; if3.in_a = 32'd1; if3.in_b = 32'd2;
      if3.in_tag = 5'(k);
      tick();
    end
    if3.in_valid = 1'b0;
    tick();
    check("rs_pre_vld", 64'(if3.out_valid), 64'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_vld0", 64'(if3.out_valid), 64'(1'b0));
    check("rs_rdy1", 64'(if3.in_ready),  64'(1'b1));
    #10;
    rst_n = 1'b1;
    tick();
    check("rs_rdy_after", 64'(if3.in_ready), 64'(1'b1));
    if3.out_ready = 1'b1;
    if3.in_valid = 1'b1; if3.in_cmpop = BR_BGE; if3.in_a = 32'd0; if3.in_b = 32'hFFFF_FFFF;
    if3.in_pred = 1'b0; if3.in_tag = 5'd4;
    tick();
    if3.in_valid = 1'b0;
    wait_out3(lat);
    check("rs_lat", 64'(lat), 64'(3));
    check("rs_res", 64'({if3.out_br_en, if3.out_mispred, if3.out_illegal, if3.out_tag}),
          64'({1'b1, 1'b1, 1'b0, 5'd4}));
    tick();

    // ---------------- WIDTH=8 random against reference ----------------
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; prev8 = '0;
    while (got < 10000 && cyc < 60000) begin
      r  = $urandom;
      ra = r[7:0];
      if8.in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
      if8.in_cmpop  = 3'($urandom_range(7));
      if8.in_a      = ra;
      r  = $urandom;
      if8.in_b      = ($urandom_range(3) == 0) ? ra : r[7:0];
      if8.in_pred   = 1'($urandom_range(1));
      if8.in_tag    = sent[4:0];
      if8.out_ready = ($urandom_range(3) != 0);
      #1;
      if (stalled) begin
        check("w8_hold",
              64'({if8.out_valid, if8.out_br_en, if8.out_mispred, if8.out_illegal, if8.out_tag}),
              64'({1'b1, prev8}));
      end
      if (if8.out_valid && if8.out_ready) begin
        if (q8.size() == 0) begin
          check("w8_spurious", 64'(1), 64'(0));
        end else begin
          e8 = q8.pop_front();
          check("w8_res", 64'({if8.out_br_en, if8.out_mispred, if8.out_illegal, if8.out_tag}), 64'(e8));
        end
        got++;
      end
      if (if8.in_valid && if8.in_ready) begin
        q8.push_back(exp8(if8.in_cmpop, if8.in_a, if8.in_b, if8.in_pred, if8.in_tag));
        sent++;
      end
      stalled = if8.out_valid && !if8.out_ready;
      prev8   = {if8.out_br_en, if8.out_mispred, if8.out_illegal, if8.out_tag};
      tick();
      cyc++;
    end
    if8.in_valid = 1'b0;
    check("w8_count", 64'(got), 64'(10000));
    check("w8_sb_empty", 64'(q8.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
